// File: rtl/sr_cmd_sequencer_pkg.sv
// Shared types and constants for the SR command sequencer.
// Package sr_seq_pkg: command encoding, FSM states and CONFLICT policy codes.
package sr_seq_pkg;

    typedef enum logic {
        CMD_CLR = 1'b0,
        CMD_SET = 1'b1
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    localparam int unsigned CONFLICT_DROP     = 0;
    localparam int unsigned CONFLICT_SET_WINS = 1;
    localparam int unsigned CONFLICT_CLR_WINS = 2;

    // Command that would leave the SR stage in state q (no-op pulse).
    function automatic cmd_t shadow_cmd(input logic q);
        return q ? CMD_SET : CMD_CLR;
    endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Command handshake bundle between a command source and sr_cmd_sequencer.
interface sr_cmd_sequencer_if;

    logic cmd_valid;
    logic cmd_ready;
    logic set_req;
    logic clr_req;

    modport master (
        output cmd_valid,
        output set_req,
        output clr_req,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  set_req,
        input  clr_req,
        output cmd_ready
    );

endinterface

// File: rtl/sr_cmd_sequencer_fifo.sv
// Command FIFO for sr_cmd_sequencer: DEPTH x cmd_t, extra pointer MSB
// distinguishes full from empty; read data is the current head.
module sr_cmd_fifo
    import sr_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // A push while full is only safe when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Replays queued set/clear commands as registered, non-overlapping s/r pulses
// for a negedge SR stage. Optional macro SRSEQ_COALESCE_EN drops no-op commands.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PULSE_W  = 1,
    parameter int unsigned GAP_W    = 1,
    parameter int unsigned CONFLICT = CONFLICT_DROP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sr_cmd_sequencer_if.slave         cmd,
    output logic                      s,
    output logic                      r,
    output logic                      q_shadow,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LD   = (GAP_W == 0) ? 4'd0 : 4'(GAP_W - 1);

    // ---------------- command intake ----------------
    logic accept;
    logic push;
    cmd_t push_cmd;
    logic conflict_drop;

    logic full;
    logic empty;
    logic pop;
    cmd_t head;

    assign cmd.cmd_ready = !full;
    assign accept        = cmd.cmd_valid && !full;

    always_comb begin
        push          = 1'b0;
        push_cmd      = CMD_CLR;
        conflict_drop = 1'b0;
        if (accept) begin
            unique case ({cmd.set_req, cmd.clr_req})
                2'b10: begin
                    push     = 1'b1;
                    push_cmd = CMD_SET;
                end
                2'b01: begin
                    push     = 1'b1;
                    push_cmd = CMD_CLR;
                end
                2'b11: begin
                    if (CONFLICT == CONFLICT_SET_WINS) begin
                        push     = 1'b1;
                        push_cmd = CMD_SET;
                    end else if (CONFLICT == CONFLICT_CLR_WINS) begin
                        push     = 1'b1;
                        push_cmd = CMD_CLR;
                    end else begin
                        conflict_drop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sr_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // ---------------- pulse sequencer ----------------
    state_t     state,    state_n;
    logic [3:0] cnt,      cnt_n;
    cmd_t       cur,      cur_n;
    logic       s_n;
    logic       r_n;
    logic       q_n;
    logic       coalesce_hit;
    logic       coalesce;

`ifdef SRSEQ_COALESCE_EN
    assign coalesce_hit = (head == shadow_cmd(q_shadow));
`else
    assign coalesce_hit = 1'b0;
`endif

    assign coalesce = (state == IDLE) && !empty && coalesce_hit;

    // s_n and r_n are derived from one cmd_t, so they can never both be 1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur;
        s_n     = s;
        r_n     = r;
        q_n     = q_shadow;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!coalesce_hit) begin
                        state_n = PULSE;
                        cnt_n   = PULSE_LD;
                        cur_n   = head;
                        s_n     = (head == CMD_SET);
                        r_n     = (head == CMD_CLR);
                    end
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    s_n = 1'b0;
                    r_n = 1'b0;
                    q_n = (cur == CMD_SET);
                    if (GAP_W > 0) begin
                        state_n = GAP;
                        cnt_n   = GAP_LD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            GAP: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 4'd1;
            end
            default: begin
                state_n = IDLE;
                s_n     = 1'b0;
                r_n     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur      <= CMD_CLR;
            s        <= 1'b0;
            r        <= 1'b0;
            q_shadow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur      <= cur_n;
            s        <= s_n;
            r        <= r_n;
            q_shadow <= q_n;
        end
    end

    // ---------------- drop counter ----------------
    // Intake and coalesce drops can coincide, so the increment is 0..2.
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    assign drop_inc = {1'b0, conflict_drop} + {1'b0, coalesce};
    assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= drop_sum[8] ? '1 : drop_sum[7:0];
    end

    assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed self-checking bench for sr_cmd_sequencer; three instances cover
// the CONFLICT policies and PULSE_W/GAP_W/DEPTH corners.
module tb_sr_cmd_sequencer;
    import sr_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    sr_cmd_sequencer_if a_if ();
    sr_cmd_sequencer_if b_if ();
    sr_cmd_sequencer_if c_if ();

    logic       a_s, a_r, a_q, a_busy;
    logic       b_s, b_r, b_q, b_busy;
    logic       c_s, c_r, c_q, c_busy;
    logic [7:0] a_drop, b_drop, c_drop;

    sr_cmd_sequencer #(.DEPTH(4), .PULSE_W(1), .GAP_W(1), .CONFLICT(CONFLICT_DROP)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(a_if), .s(a_s), .r(a_r),
        .q_shadow(a_q), .busy(a_busy), .drop_cnt(a_drop));

    sr_cmd_sequencer #(.DEPTH(4), .PULSE_W(8), .GAP_W(1), .CONFLICT(CONFLICT_SET_WINS)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(b_if), .s(b_s), .r(b_r),
        .q_shadow(b_q), .busy(b_busy), .drop_cnt(b_drop));

    sr_cmd_sequencer #(.DEPTH(2), .PULSE_W(1), .GAP_W(0), .CONFLICT(CONFLICT_CLR_WINS)) dut_c (
        .clk(clk), .rst_n(rst_n), .cmd(c_if), .s(c_s), .r(c_r),
        .q_shadow(c_q), .busy(c_busy), .drop_cnt(c_drop));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v, input logic st, input logic cl);
        case (which)
            0:       begin a_if.cmd_valid = v; a_if.set_req = st; a_if.clr_req = cl; end
            1:       begin b_if.cmd_valid = v; b_if.set_req = st; b_if.clr_req = cl; end
            default: begin c_if.cmd_valid = v; c_if.set_req = st; c_if.clr_req = cl; end
        endcase
    endtask

    function automatic logic ready_of(input int which);
        case (which)
            0:       return a_if.cmd_ready;
            1:       return b_if.cmd_ready;
            default: return c_if.cmd_ready;
        endcase
    endfunction

    function automatic logic busy_of(input int which);
        case (which)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    // Offer one command, wait (bounded) for ready, let it be accepted.
    task automatic push(input int which, input logic st, input logic cl, input string tag);
        int g;
        g = 0;
        drive(which, 1'b1, st, cl);
        while (!ready_of(which) && g < 100) begin
            tick();
            g++;
        end
        chk(tag, ready_of(which), 1);
        tick();
        drive(which, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int which, input string tag);
        int g;
        g = 0;
        while (busy_of(which) && g < 300) begin
            tick();
            g++;
        end
        chk(tag, busy_of(which), 0);
    endtask

    // s and r must never be high together on any instance.
    always @(negedge clk) begin
        chk("a_s_and_r", {31'b0, a_s & a_r}, 0);
        chk("b_s_and_r", {31'b0, b_s & b_r}, 0);
        chk("c_s_and_r", {31'b0, c_s & c_r}, 0);
    end

    // Pulse recorders: 1 = s pulse started, 0 = r pulse started.
    logic b_s_d = 1'b0, b_r_d = 1'b0, c_s_d = 1'b0, c_r_d = 1'b0;
    int   b_s_cyc = 0, b_r_cyc = 0;
    logic qb[$];
    logic qc[$];

    always @(negedge clk) begin
        if (b_s && !b_s_d) qb.push_back(1'b1);
        if (b_r && !b_r_d) qb.push_back(1'b0);
        if (c_s && !c_s_d) qc.push_back(1'b1);
        if (c_r && !c_r_d) qc.push_back(1'b0);
        b_s_d   <= b_s;
        b_r_d   <= b_r;
        c_s_d   <= c_s;
        c_r_d   <= c_r;
        b_s_cyc <= b_s_cyc + int'(b_s);
        b_r_cyc <= b_r_cyc + int'(b_r);
    end

    logic [1:0] burst_exp [13];
    logic       exp_c[$];
    logic [7:0] exp_c_drop;
    int         g;

    initial begin
        burst_exp = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00,
                      2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
`ifdef SRSEQ_COALESCE_EN
        exp_c      = {1'b1, 1'b0, 1'b1, 1'b0};
        exp_c_drop = 8'd1;
`else
        exp_c      = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_c_drop = 8'd0;
`endif
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_s", a_s, 0);
        chk("rst_r", a_r, 0);
        chk("rst_q", a_q, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_b_s", b_s, 0);
        rst_n = 1'b1;

        // Single SET: one-cycle s pulse, then gap, then idle
        drive(0, 1'b1, 1'b1, 1'b0);
        chk("t1_ready", a_if.cmd_ready, 1);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("t1_s_acc", a_s, 0);
        chk("t1_busy_acc", a_busy, 1);
        tick();
        chk("t1_s_hi", a_s, 1);
        chk("t1_r_lo", a_r, 0);
        tick();
        chk("t1_s_lo", a_s, 0);
        chk("t1_q", a_q, 1);
        chk("t1_busy_gap", a_busy, 1);
        tick();
        chk("t1_busy_idle", a_busy, 0);

        // Burst SET,CLR,SET,CLR: 3-cycle spacing, 12 cycles of activity
        for (int i = 0; i < 13; i++) begin
            if (i < 4) begin
                drive(0, 1'b1, (i % 2) == 0, (i % 2) == 1);
                chk($sformatf("burst_ready%0d", i), a_if.cmd_ready, 1);
            end else begin
                drive(0, 1'b0, 1'b0, 1'b0);
            end
            tick();
            chk($sformatf("burst_sr%0d", i), {a_s, a_r}, burst_exp[i]);
        end
        chk("burst_q", a_q, 0);
        chk("burst_busy", a_busy, 0);

        // Conflict with drop policy, then drop_cnt saturation
        drive(0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("cdrop_cnt", a_drop, 1);
        tick();
        chk("cdrop_s", a_s, 0);
        chk("cdrop_r", a_r, 0);
        chk("cdrop_busy", a_busy, 0);
        drive(0, 1'b1, 1'b1, 1'b1);
        repeat (260) tick();
        chk("sat_cnt", a_drop, 255);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("sat_hold", a_drop, 255);

        // Overflow on B (PULSE_W=8): 5 accepted, 6th stalls 7 cycles
        for (int k = 0; k < 6; k++) begin
            drive(1, 1'b1, (k % 2) == 0, (k % 2) == 1);
            if (k == 5) chk("ovf_full", b_if.cmd_ready, 0);
            g = 0;
            while (!b_if.cmd_ready && g < 100) begin
                tick();
                g++;
            end
            if (k == 5) chk("ovf_stall", g, 7);
            tick();
        end
        drive(1, 1'b0, 1'b0, 1'b0);
        wait_idle(1, "ovf_drain");
        chk("ovf_len", qb.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("ovf_ord%0d", i), (i < qb.size()) ? qb[i] : 1'bx, (i % 2) == 0);
        chk("ovf_s_cyc", b_s_cyc, 24);
        chk("ovf_r_cyc", b_r_cyc, 24);

        // Conflict with set-wins on B
        push(1, 1'b1, 1'b1, "cset_push");
        wait_idle(1, "cset_drain");
        chk("cset_len", qb.size(), 7);
        chk("cset_pulse", (qb.size() > 6) ? qb[6] : 1'bx, 1);
        chk("cset_drop", b_drop, 0);
        chk("cset_q", b_q, 1);

        // Clear-wins on C (GAP_W=0, DEPTH=2), then SET,SET,CLR
        push(2, 1'b1, 1'b0, "c_set_push");
        wait_idle(2, "c_set_drain");
        push(2, 1'b1, 1'b1, "cclr_push");
        wait_idle(2, "cclr_drain");
        chk("cclr_q", c_q, 0);
        push(2, 1'b1, 1'b0, "coal_push0");
        push(2, 1'b1, 1'b0, "coal_push1");
        push(2, 1'b0, 1'b1, "coal_push2");
        wait_idle(2, "coal_drain");
        chk("coal_len", qc.size(), exp_c.size());
        for (int i = 0; i < exp_c.size(); i++)
            chk($sformatf("coal_ord%0d", i), (i < qc.size()) ? qc[i] : 1'bx, exp_c[i]);
        chk("coal_drop", c_drop, exp_c_drop);
        chk("coal_q", c_q, 0);

        // Asynchronous reset during an s pulse with a command still queued
        push(0, 1'b1, 1'b0, "arst_push0");
        push(0, 1'b0, 1'b1, "arst_push1");
        chk("arst_s_hi", a_s, 1);
        chk("arst_busy_hi", a_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s", a_s, 0);
        chk("arst_r", a_r, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_drop", a_drop, 0);
        chk("arst_ready", a_if.cmd_ready, 1);
        chk("arst_q", a_q, 0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("arst_post_s", a_s, 0);
        chk("arst_post_r", a_r, 0);
        chk("arst_post_busy", a_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
